fifo_wr_arb: RTL and testbench

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_wr_arb_rr.sv | 26 ++
 rtl/fifo_wr_arb.sv | 102 ++++++++++
 tb/tb_fifo_wr_arb.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO write-side blocks.
package fifo_pkg;

  localparam int unsigned DATASIZE_DEF = 8;
  localparam int unsigned ADDRSIZE_DEF = 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Round-robin pointer width; never below 1 bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr.sv
// Combinational round-robin arbiter: lowest requester at or above rr_ptr wins, else wraps to lowest overall.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned RRW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [RRW-1:0]  rr_ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt
);

  logic [NREQ-1:0] w_upper;
  logic [NREQ-1:0] w_src;

  always_comb begin
    w_upper = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_upper[i] = req[i] & (i >= 32'(rr_ptr));
    end
  end

  // Isolate the lowest set bit of the chosen search window.
  assign w_src = (|w_upper) ? w_upper : req;
  assign gnt   = en ? (w_src & (~w_src + 1'b1)) : '0;

endmodule

// File: rtl/fifo_wr_arb.sv
// FIFO write side with NREQ-way round-robin write arbitration and Gray pointer/full logic.
// Optional macro FIFO_WR_ARB_PRIO_EN: requester 0 gets fixed priority, others share round-robin.
module fifo_wr_arb
  import fifo_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned DATASIZE = DATASIZE_DEF,
  parameter int unsigned ADDRSIZE = ADDRSIZE_DEF
) (
  input  logic                     wclk,
  input  logic                     wrst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATASIZE-1:0] req_data,
  input  logic [ADDRSIZE:0]        wq2_rptr,
  output logic [NREQ-1:0]          gnt,
  output logic                     wclken,
  output logic [ADDRSIZE-1:0]      waddr,
  output logic [DATASIZE-1:0]      wdata,
  output logic [ADDRSIZE:0]        wptr,
  output logic                     wfull
);

  localparam int unsigned RRW = clog2(NREQ);

  logic [RRW-1:0]      r_rr_ptr;
  logic [RRW-1:0]      w_gidx;
  logic [RRW-1:0]      w_rr_next;
  logic [ADDRSIZE:0]   r_wbin;
  logic [ADDRSIZE:0]   r_wptr;
  logic [ADDRSIZE:0]   w_wbinnext;
  logic [ADDRSIZE:0]   w_wgraynext;
  logic                r_wfull;
  logic                w_full_next;
  logic                w_en;
  logic                w_wclken;
  logic [NREQ-1:0]     w_arb_req;
  logic [NREQ-1:0]     w_arb_gnt;
  logic [NREQ-1:0]     w_gnt;
  logic [DATASIZE-1:0] w_wdata;

`ifdef FIFO_WR_ARB_PRIO_EN
  logic w_prio;
  // Requester 0 bypasses the arbiter, so rr_ptr only ever sees grants to 1..NREQ-1.
  assign w_prio    = req[0] & ~r_wfull & ~wrst;
  assign w_arb_req = {req[NREQ-1:1], 1'b0};
  assign w_en      = ~r_wfull & ~wrst & ~req[0];
  assign w_gnt     = w_arb_gnt | {{(NREQ-1){1'b0}}, w_prio};
`else
  assign w_arb_req = req;
  assign w_en      = ~r_wfull & ~wrst;
  assign w_gnt     = w_arb_gnt;
`endif

  rr_arbiter #(
    .NREQ (NREQ),
    .RRW  (RRW)
  ) u_arb (
    .req    (w_arb_req),
    .rr_ptr (r_rr_ptr),
    .en     (w_en),
    .gnt    (w_arb_gnt)
  );

  always_comb begin
    w_gidx  = '0;
    w_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_gidx  = RRW'(i);
        w_wdata = req_data[i*DATASIZE +: DATASIZE];
      end
    end
  end

  assign w_rr_next   = (w_gidx == RRW'(NREQ-1)) ? '0 : w_gidx + 1'b1;
  assign w_wclken    = |w_gnt;
  assign w_wbinnext  = r_wbin + {{ADDRSIZE{1'b0}}, w_wclken};
  assign w_wgraynext = (ADDRSIZE+1)'(bin2gray(32'(w_wbinnext)));
  assign w_full_next = (w_wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_wbin   <= '0;
      r_wptr   <= '0;
      r_wfull  <= 1'b0;
      r_rr_ptr <= '0;
    end else begin
      r_wbin  <= w_wbinnext;
      r_wptr  <= w_wgraynext;
      r_wfull <= w_full_next;
      if (|w_arb_gnt) r_rr_ptr <= w_rr_next;
    end
  end

  assign gnt    = w_gnt;
  assign wclken = w_wclken;
  assign waddr  = r_wbin[ADDRSIZE-1:0];
  assign wdata  = w_wdata;
  assign wptr   = r_wptr;
  assign wfull  = r_wfull;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: queue-level model checked every cycle plus directed literal expectations.
module tb_fifo_wr_arb;

  localparam int NREQ = 4;

  logic        wclk = 1'b0;
  logic        wrst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [4:0]  wq2_rptr;
  logic [3:0]  gnt;
  logic        wclken;
  logic [3:0]  waddr;
  logic [7:0]  wdata;
  logic [4:0]  wptr;
  logic        wfull;

  int vectors = 0;
  int errors  = 0;
  logic [7:0] n = 8'd0;

  int m_wbin = 0;
  int m_rr   = 0;
  bit m_full = 1'b0;

  always #5 wclk = ~wclk;

  fifo_wr_arb #(.NREQ(4), .DATASIZE(8), .ADDRSIZE(4)) dut (
    .wclk     (wclk),
    .wrst     (wrst),
    .req      (req),
    .req_data (req_data),
    .wq2_rptr (wq2_rptr),
    .gnt      (gnt),
    .wclken   (wclken),
    .waddr    (waddr),
    .wdata    (wdata),
    .wptr     (wptr),
    .wfull    (wfull)
  );

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int g2b(input int g);
    return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3) ^ (g >> 4);
  endfunction

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  // Index the model expects to win this cycle, -1 for none.
  function automatic int exp_idx();
    int idx;
    if (wrst || m_full) return -1;
`ifdef FIFO_WR_ARB_PRIO_EN
    if (req[0]) return 0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_rr + k) % NREQ;
`ifdef FIFO_WR_ARB_PRIO_EN
      if (idx != 0 && req[idx]) return idx;
`else
      if (req[idx]) return idx;
`endif
    end
    return -1;
  endfunction

  always @(posedge wclk or posedge wrst) begin : model
    int g;
    if (wrst) begin
      m_wbin = 0;
      m_rr   = 0;
      m_full = 1'b0;
    end else begin
      g = exp_idx();
      if (g >= 0) begin
        m_wbin = (m_wbin + 1) % 32;
`ifdef FIFO_WR_ARB_PRIO_EN
        if (g != 0) m_rr = (g + 1) % NREQ;
`else
        m_rr = (g + 1) % NREQ;
`endif
      end
      m_full = (((m_wbin - g2b(int'(wq2_rptr))) & 31) == 16);
    end
  end

  always @(negedge wclk) begin : compare
    int g;
    int eg;
    int ed;
    g  = exp_idx();
    eg = (g >= 0) ? (1 << g) : 0;
    ed = (g >= 0) ? int'(req_data[g*8 +: 8]) : 0;
    check("gnt",    int'(gnt),    eg);
    check("wclken", int'(wclken), (g >= 0) ? 1 : 0);
    check("waddr",  int'(waddr),  m_wbin % 16);
    check("wdata",  int'(wdata),  ed);
    check("wptr",   int'(wptr),   gray(m_wbin));
    check("wfull",  int'(wfull),  int'(m_full));
  end

  task automatic cyc();
    @(posedge wclk);
    #1;
    n = n + 8'd1;
    req_data = {8'h30 + n, 8'h20 + n, 8'h10 + n, n};
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int wr;
    bit saw10;
    bit saw00;
    wrst = 1'b1; req = '0; wq2_rptr = '0; req_data = '0;
    repeat (2) @(posedge wclk);
    #1;
    check("rst_gnt",    int'(gnt),    0);
    check("rst_wclken", int'(wclken), 0);
    check("rst_wptr",   int'(wptr),   0);
    check("rst_wfull",  int'(wfull),  0);
    wrst = 1'b0;
    req  = 4'b1111;

    // Fill 16 slots with the read pointer parked at 0.
    for (int i = 0; i < 16; i++) begin
      #1;
`ifndef FIFO_WR_ARB_PRIO_EN
      check("fill_gnt", int'(gnt), 1 << (i % 4));
`endif
      check("fill_waddr", int'(waddr), i);
      cyc();
    end
    check("full_set",  int'(wfull), 1);
    check("full_gnt",  int'(gnt),   0);
    check("full_wptr", int'(wptr),  'h18);
    repeat (2) cyc();
    check("full_hold_gnt", int'(gnt), 0);

    // One read frees exactly one slot.
    wq2_rptr = 5'h01;
    #1;
    check("full_before_rd", int'(wfull), 1);
    cyc();
    check("full_clear",  int'(wfull), 0);
    check("free_gnt",    int'(gnt),   1);
    check("free_waddr",  int'(waddr), 0);
    cyc();
    check("full_again", int'(wfull), 1);
    wr = 0;
    repeat (3) begin
      wr += int'(wclken);
      cyc();
    end
    check("one_write_only", wr, 0);

    // Sparse requesters on an empty FIFO.
    req = 4'b0000; wq2_rptr = 5'h19;
    cyc();
    req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      #1;
`ifndef FIFO_WR_ARB_PRIO_EN
      check("alt_gnt", int'(gnt), (i % 2 == 0) ? 4 : 1);
`endif
      cyc();
    end

    // 40 writes with the reader trailing by two, crossing the pointer wrap.
    req = 4'b1111; saw10 = 1'b0; saw00 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      wq2_rptr = 5'(gray((m_wbin + 30) % 32));
      cyc();
      if (wptr == 5'h10) saw10 = 1'b1;
      else if (saw10 && wptr == 5'h00) saw00 = 1'b1;
    end
    check("wrap_wptr", int'(wptr), 'h13);
    check("wrap_saw10", int'(saw10), 1);
    check("wrap_saw00", int'(saw00), 1);

    // Fill again past the wrap point.
    wq2_rptr = 5'h13; wr = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (wfull) break;
      wr += int'(wclken);
      cyc();
    end
    check("wrap_fill_writes", wr, 16);
    check("wrap_full",        int'(wfull), 1);
    check("wrap_full_wptr",   int'(wptr),  'h0B);

    // Reset while requester 3 holds a grant.
    wq2_rptr = 5'h0B;
    cyc();
    req = 4'b1000;
    #1;
    check("pre_rst_gnt", int'(gnt), 8);
    wrst = 1'b1;
    #1;
    check("rst_mid_wclken", int'(wclken), 0);
    check("rst_mid_gnt",    int'(gnt),    0);
    repeat (2) cyc();
    check("rst_mid_wptr", int'(wptr), 0);
    wq2_rptr = '0;
    wrst = 1'b0;
    #1;
    check("post_rst_gnt",   int'(gnt),   8);
    check("post_rst_waddr", int'(waddr), 0);
    cyc();
    check("post_rst_wptr", int'(wptr), 1);

`ifdef FIFO_WR_ARB_PRIO_EN
    req = 4'b0111;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("prio_gnt0", int'(gnt), 1);
      cyc();
    end
    req = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("prio_rr_gnt", int'(gnt), (i % 2 == 0) ? 2 : 4);
      cyc();
    end
`endif

    req = '0;
    repeat (2) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
